// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Sequences the CPU clock-enable between halted, free-running, slow-running
//   (divider-paced) and single-step execution. The CPU's HLT instruction stops
//   execution through cpu_halt_i.
//
// Parameters
//   ClockFrequency  input clock in Hz; documentation only
//   DivWidth        width of divisor_i and of the tick down-counter
//
// Ports
//   clk_i          system clock, all logic on posedge
//   reset_i        synchronous active-high reset
//   start_i        level, halted -> run request
//   stop_i         level, run -> halted request (wins over start and step)
//   step_req_i     synchronised step button, rising edge requests one step
//   slow_mode_i    0: enable every run cycle, 1: enable only on divider tick
//   divisor_i      divider reload value, tick period = divisor_i + 1 cycles
//   cpu_halt_i     CPU executed HLT, forces halted while running
//   cpu_enable_o   registered clock-enable to the CPU core
//   state_o        00 halted, 01 run, 10 step
//   running_o      registered copy of (state_o == run)

module cpu_run_controller #(
    parameter int unsigned ClockFrequency = 50000000,
    parameter int unsigned DivWidth       = 26
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                step_req_i,
    input  logic                slow_mode_i,
    input  logic [DivWidth-1:0] divisor_i,
    input  logic                cpu_halt_i,
    output logic                cpu_enable_o,
    output logic [1:0]          state_o,
    output logic                running_o
);

    if (ClockFrequency == 0) begin : g_clk_check
        $error("ClockFrequency must be non-zero");
    end

    typedef enum logic [1:0] {
        StHalted = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10
    } state_e;

    state_e              state_q;
    logic                cpu_enable_q;
    logic                running_q;
    logic                step_prev_q;
    logic [DivWidth-1:0] count_q;

    logic step_edge;
    logic tick;

    assign step_edge = step_req_i & ~step_prev_q;
    assign tick      = (count_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StHalted;
            cpu_enable_q <= 1'b0;
            running_q    <= 1'b0;
            count_q      <= divisor_i;
            // Treat the button as already pressed so a press held through
            // reset does not produce a step.
            step_prev_q  <= 1'b1;
        end else begin
            step_prev_q <= step_req_i;
            unique case (state_q)
                StHalted: begin
                    cpu_enable_q <= 1'b0;
                    if (stop_i) begin
                        state_q <= StHalted;
                    end else if (start_i) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                        count_q   <= divisor_i;
                    end else if (step_edge) begin
                        state_q      <= StStep;
                        cpu_enable_q <= 1'b1;
                    end
                end
                StStep: begin
                    // One enable pulse per step; every input is ignored here.
                    cpu_enable_q <= 1'b0;
                    state_q      <= StHalted;
                end
                StRun: begin
                    // Divider runs every RUN cycle, even while in fast mode.
                    if (tick) begin
                        count_q <= divisor_i;
                    end else begin
                        count_q <= count_q - DivWidth'(1);
                    end
                    if (stop_i || cpu_halt_i) begin
                        state_q      <= StHalted;
                        running_q    <= 1'b0;
                        cpu_enable_q <= 1'b0;
                    end else if (slow_mode_i) begin
                        cpu_enable_q <= tick;
                    end else begin
                        cpu_enable_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= StHalted;
                    running_q    <= 1'b0;
                    cpu_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_enable_o = cpu_enable_q;
    assign state_o      = state_q;
    assign running_o    = running_q;

endmodule
